// File: rtl/pov_column_sequencer_pkg.sv
// Shared types and default sizing for the POV column sequencer.
package pov_column_sequencer_pkg;

  localparam int unsigned NUM_COL_DEF   = 32;
  localparam int unsigned ANCHO_LED_DEF = 8;
  localparam int unsigned COL_W_DEF     = 6;

  typedef enum logic [1:0] {
    ESPERA  = 2'd0,
    BARRIDO = 2'd1,
    PAUSA   = 2'd2
  } estado_e;

endpackage

// File: rtl/pov_column_sequencer_edge_sync.sv
// Optional N-stage synchroniser followed by a one-cycle rising-edge pulse.
module pov_column_sequencer_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse_c
);

  logic sync_c;
  logic prev_q, prev_d;

  if (SYNC_STAGES == 0) begin : g_direct
    assign sync_c = d;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q, sync_d;

    always_comb sync_d = SYNC_STAGES'({sync_q, d});

    always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '0;
      else     sync_q <= sync_d;
    end

    assign sync_c = sync_q[SYNC_STAGES-1];
  end

  assign prev_d = sync_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= prev_d;
  end

  assign pulse_c = sync_c & ~prev_q;

endmodule

// File: rtl/pov_column_sequencer.sv
// Steps LED columns through a frame on each Frec tick, resynchronised by the hall index.
module pov_column_sequencer
  import pov_column_sequencer_pkg::*;
#(
  parameter int unsigned NUM_COL   = NUM_COL_DEF,
  parameter int unsigned ANCHO_LED = ANCHO_LED_DEF,
  parameter int unsigned COL_W     = COL_W_DEF
) (
  input  logic                 Reloj,
  input  logic                 Reset,
  input  logic                 Frec,
  input  logic                 Sensor,
  input  logic                 Habilitar,
  input  logic                 WrEn,
  input  logic [COL_W-1:0]     WrAddr,
  input  logic [ANCHO_LED-1:0] WrData,
  output logic [ANCHO_LED-1:0] Leds,
  output logic [COL_W-1:0]     Columna,
  output logic                 FinCuadro,
  output logic                 Activo
);

  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(NUM_COL - 1);
  localparam logic [COL_W:0]   NUM_COL_X = (COL_W+1)'(NUM_COL);

  logic                 tick_c, sinc_c, wr_ok_c;
  estado_e              state_q, state_d;
  logic [COL_W-1:0]     col_q, col_d, col_inc_c;
  logic [ANCHO_LED-1:0] leds_q, leds_d, mem_nxt_c;
  logic                 fin_q, fin_d;
  logic                 activo_q, activo_d;
  logic [ANCHO_LED-1:0] mem_q [NUM_COL];
  logic [ANCHO_LED-1:0] mem_d [NUM_COL];

  pov_column_sequencer_edge_sync #(.SYNC_STAGES(0)) u_frec_edge (
    .clk     (Reloj),
    .rst     (Reset),
    .d       (Frec),
    .pulse_c (tick_c)
  );

  pov_column_sequencer_edge_sync #(.SYNC_STAGES(2)) u_sensor_edge (
    .clk     (Reloj),
    .rst     (Reset),
    .d       (Sensor),
    .pulse_c (sinc_c)
  );

  // Out-of-range addresses are dropped rather than aliased onto a real column.
  assign wr_ok_c = WrEn && ({1'b0, WrAddr} < NUM_COL_X);

  always_comb begin
    for (int unsigned i = 0; i < NUM_COL; i++) begin
      mem_d[i] = (wr_ok_c && (WrAddr == COL_W'(i))) ? WrData : mem_q[i];
    end
  end

  assign col_inc_c = col_q + COL_W'(1);

  always_comb begin
    mem_nxt_c = '0;
    for (int unsigned i = 0; i < NUM_COL; i++) begin
      if (col_inc_c == COL_W'(i)) mem_nxt_c = mem_q[i];
    end
  end

  // Next-state and output decode; sinc outranks tick, Habilitar low outranks everything.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    leds_d  = leds_q;
    fin_d   = 1'b0;

    unique case (state_q)
      ESPERA: begin
        col_d  = '0;
        leds_d = '0;
        if (sinc_c) begin
          state_d = BARRIDO;
          leds_d  = mem_q[0];
        end
      end
      BARRIDO: begin
        if (sinc_c) begin
          col_d  = '0;
          leds_d = mem_q[0];
        end else if (tick_c) begin
          if (col_q == LAST_COL) begin
            fin_d   = 1'b1;
            col_d   = '0;
            leds_d  = '0;
            state_d = PAUSA;
          end else begin
            col_d  = col_inc_c;
            leds_d = mem_nxt_c;
          end
        end
      end
      PAUSA: begin
        col_d  = '0;
        leds_d = '0;
        if (sinc_c) begin
          state_d = BARRIDO;
          leds_d  = mem_q[0];
        end
      end
      default: begin
        state_d = ESPERA;
        col_d   = '0;
        leds_d  = '0;
      end
    endcase

    if (!Habilitar) begin
      state_d = ESPERA;
      col_d   = '0;
      leds_d  = '0;
      fin_d   = 1'b0;
    end
  end

  assign activo_d = (state_d == BARRIDO);

  always_ff @(posedge Reloj or posedge Reset) begin
    if (Reset) begin
      state_q  <= ESPERA;
      col_q    <= '0;
      leds_q   <= '0;
      fin_q    <= 1'b0;
      activo_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      leds_q   <= leds_d;
      fin_q    <= fin_d;
      activo_q <= activo_d;
    end
  end

  always_ff @(posedge Reloj or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < NUM_COL; i++) mem_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_COL; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign Leds      = leds_q;
  assign Columna   = col_q;
  assign FinCuadro = fin_q;
  assign Activo    = activo_q;

endmodule
